// File: rtl/ovsclk_pkg.sv
// Shared types and constants for the oversampling clock generator and its
// serial divider.
package ovsclk_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DIV,
      DONE
   } div_state_e;

   localparam int unsigned PROD_W    = 37;
   localparam int unsigned DIVISOR_W = PROD_W + 1;
   localparam int unsigned DIV_ITER  = 32;
   localparam int unsigned ITER_W    = $clog2(DIV_ITER);
   localparam int unsigned H_MIN     = 1;

endpackage

// File: rtl/ovsclk_serial_div.sv
// Serial restoring divider: one quotient bit per cycle, DIV_ITER iterations.
// A start pulse in any state aborts the current job and reloads the operands.
`timescale 1ns/1ps
module ovsclk_serial_div
   import ovsclk_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [DIV_ITER-1:0]  dividend,
   input  logic [DIVISOR_W-1:0] divisor,
   output logic                 busy,
   output logic                 done,
   output logic [DIV_ITER-1:0]  quotient
);

   div_state_e           state_q, state_d;
   logic [ITER_W-1:0]    iter_q, iter_d;
   logic [DIVISOR_W:0]   rem_q, rem_d;
   logic [DIV_ITER-1:0]  quo_q, quo_d;
   logic [DIVISOR_W-1:0] dsr_q, dsr_d;
   logic [DIVISOR_W:0]   rem_shift;

   always_comb begin
      state_d   = state_q;
      iter_d    = iter_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dsr_d     = dsr_q;
      // quo_q doubles as the dividend shift register: its MSB feeds the remainder
      rem_shift = {rem_q[DIVISOR_W-1:0], quo_q[DIV_ITER-1]};

      case (state_q)
         IDLE: ;
         DIV: begin
            if (rem_shift >= {1'b0, dsr_q}) begin
               rem_d = rem_shift - {1'b0, dsr_q};
               quo_d = {quo_q[DIV_ITER-2:0], 1'b1};
            end else begin
               rem_d = rem_shift;
               quo_d = {quo_q[DIV_ITER-2:0], 1'b0};
            end
            iter_d = iter_q + 1'b1;
            if (iter_q == ITER_W'(DIV_ITER - 1)) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (start) begin
         state_d = DIV;
         iter_d  = '0;
         rem_d   = '0;
         quo_d   = dividend;
         dsr_d   = divisor;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         iter_q  <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dsr_q   <= '0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dsr_q   <= dsr_d;
      end
   end

   assign busy     = (state_q == DIV);
   assign done     = (state_q == DONE);
   assign quotient = quo_q;

endmodule

// File: rtl/oversampling_clk_generator.sv
// 50% duty square wave at rate_bd*oversampling_factor Hz from a CLK_FREQ_HZ clock.
// Optional macro OVSCLK_TICK_EN adds ovs_tick, a pulse on each output rising edge.
`timescale 1ns/1ps
module oversampling_clk_generator
   import ovsclk_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] rate_bd,
   input  logic [4:0]  oversampling_factor,
   output logic        oversampling_clock
`ifdef OVSCLK_TICK_EN
   ,
   output logic        ovs_tick
`endif
);

   logic [31:0]          cap_rate_q, cap_rate_d;
   logic [4:0]           cap_ovs_q, cap_ovs_d;
   logic                 out_q, out_d;
   logic [31:0]          cnt_q, cnt_d;
   logic [31:0]          act_h_q, act_h_d;
   logic                 act_vld_q, act_vld_d;
   logic [31:0]          pend_h_q, pend_h_d;
   logic                 pend_vld_q, pend_vld_d;

   logic                 change, new_zero, cap_zero, force_zero, accept;
   logic [PROD_W-1:0]    prod_in;
   logic [DIVISOR_W-1:0] divisor;
   logic [31:0]          h_new;
   logic                 div_busy, div_done;
   logic [DIV_ITER-1:0]  div_quo;

   assign change   = (rate_bd != cap_rate_q) || (oversampling_factor != cap_ovs_q);
   assign new_zero = (rate_bd == '0) || (oversampling_factor == '0);
   assign cap_zero = (cap_rate_q == '0) || (cap_ovs_q == '0);
   // A zero product takes effect on the capturing edge itself, not a cycle later
   assign force_zero = change ? new_zero : cap_zero;
   assign prod_in  = PROD_W'(rate_bd) * PROD_W'(oversampling_factor);
   assign divisor  = {prod_in, 1'b0};
   assign accept   = div_done && !cap_zero && !change;
   assign h_new    = (div_quo < H_MIN) ? H_MIN : div_quo;

   ovsclk_serial_div u_div (
      .clk      (clk),
      .rst_n    (rst),
      .start    (change),
      .dividend (CLK_FREQ_HZ),
      .divisor  (divisor),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quo)
   );

   always_comb begin
      cap_rate_d = change ? rate_bd : cap_rate_q;
      cap_ovs_d  = change ? oversampling_factor : cap_ovs_q;
      out_d      = out_q;
      cnt_d      = cnt_q;
      act_h_d    = act_h_q;
      act_vld_d  = act_vld_q;
      pend_h_d   = pend_h_q;
      pend_vld_d = pend_vld_q;

      if (force_zero) begin
         out_d      = 1'b0;
         cnt_d      = '0;
         act_vld_d  = 1'b0;
         pend_vld_d = 1'b0;
      end else begin
         if (act_vld_q) begin
            if (cnt_q == act_h_q - 32'd1) begin
               out_d = ~out_q;
               cnt_d = '0;
               if (pend_vld_q) begin
                  act_h_d    = pend_h_q;
                  pend_vld_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         // A pending value is stale once a newer division has been launched
         if (change || div_busy) pend_vld_d = 1'b0;
         if (accept) begin
            if (act_vld_q) begin
               pend_h_d   = h_new;
               pend_vld_d = 1'b1;
            end else begin
               act_h_d   = h_new;
               act_vld_d = 1'b1;
               cnt_d     = '0;
               out_d     = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_rate_q <= '0;
         cap_ovs_q  <= '0;
         out_q      <= 1'b0;
         cnt_q      <= '0;
         act_h_q    <= '0;
         act_vld_q  <= 1'b0;
         pend_h_q   <= '0;
         pend_vld_q <= 1'b0;
      end else begin
         cap_rate_q <= cap_rate_d;
         cap_ovs_q  <= cap_ovs_d;
         out_q      <= out_d;
         cnt_q      <= cnt_d;
         act_h_q    <= act_h_d;
         act_vld_q  <= act_vld_d;
         pend_h_q   <= pend_h_d;
         pend_vld_q <= pend_vld_d;
      end
   end

   assign oversampling_clock = out_q;

`ifdef OVSCLK_TICK_EN
   logic tick_q, tick_d;

   assign tick_d = out_d & ~out_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) tick_q <= 1'b0;
      else      tick_q <= tick_d;
   end

   assign ovs_tick = tick_q;
`endif

endmodule

// File: tb/tb_oversampling_clk_generator.sv
// Scoreboard bench: stimulus queues expected output phases (level, length in clks),
// a monitor measures each phase at every output toggle and compares.
`timescale 1ns/1ps
module tb_oversampling_clk_generator;

   typedef struct {
      bit lvl;
      int len;
   } phase_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] rate_bd = '0;
   logic [4:0]  oversampling_factor = '0;
   logic        oversampling_clock;
`ifdef OVSCLK_TICK_EN
   logic        ovs_tick;
`endif

   oversampling_clk_generator #(.CLK_FREQ_HZ(100_000_000)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .rate_bd             (rate_bd),
      .oversampling_factor (oversampling_factor),
      .oversampling_clock  (oversampling_clock)
`ifdef OVSCLK_TICK_EN
      ,
      .ovs_tick            (ovs_tick)
`endif
   );

   always #5 clk = ~clk;

   int     n_checks = 0;
   int     n_fails  = 0;
   phase_t exp_q[$];
   longint cyc = 0;
   longint last_cyc = 0;
   bit     prev_lvl = 1'b0;
   bit     mon_lvl = 1'b0;
   int     n_toggles = 0;
   event   tog_ev;

   function automatic void check(string name, longint act, longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Monitor: measure every completed output phase and pop its expectation
   always @(negedge clk) begin
      phase_t e;
      cyc++;
      if (!rst) begin
         prev_lvl = 1'b0;
         last_cyc = cyc;
      end else begin
`ifdef OVSCLK_TICK_EN
         check("ovs_tick", longint'(ovs_tick), longint'(oversampling_clock && !prev_lvl));
`endif
         if (oversampling_clock !== prev_lvl) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("phase_lvl", longint'(prev_lvl), longint'(e.lvl));
               check("phase_len", cyc - last_cyc, longint'(e.len));
            end
            n_toggles++;
            last_cyc = cyc;
            prev_lvl = oversampling_clock;
            mon_lvl  = oversampling_clock;
            ->tog_ev;
         end
      end
   end

   task automatic push_phases(input bit first_lvl, input int len, input int n);
      bit l = first_lvl;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{lvl: l, len: len});
         l = ~l;
      end
   endtask

   task automatic wait_rise(input int budget, input string name);
      bit got = 1'b0;
      fork
         begin
            while (!got) begin
               @(tog_ev);
               if (mon_lvl) got = 1'b1;
            end
         end
         begin
            repeat (budget) @(posedge clk);
         end
      join_any
      disable fork;
      check(name, longint'(got), 1);
   endtask

   task automatic wait_drain(input int budget, input string name);
      for (int i = 0; i < budget && exp_q.size() > 0; i++) @(posedge clk);
      check(name, longint'(exp_q.size()), 0);
      exp_q.delete();
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   initial begin
      int t0;
      // Reset state
      rate_bd = 32'd5_000_000;
      oversampling_factor = 5'd16;
      step(3);
      check("rst_out", longint'(oversampling_clock), 0);
`ifdef OVSCLK_TICK_EN
      check("rst_tick", longint'(ovs_tick), 0);
`endif
      // 5 MHz x16 clamps to H=1: 50 MHz output within 40 clks of release
      rst = 1'b1;
      wait_rise(40, "h1_start");
      push_phases(1'b1, 1, 8);
      wait_drain(40, "h1_drain");

      // 115200 x16 -> H=27
      rate_bd = 32'd115_200;
      step(60);
      wait_rise(100, "h27_start");
      push_phases(1'b1, 27, 6);
      wait_drain(400, "h27_drain");

      // factor 8 mid high phase: two old phases complete, then H=54
      wait_rise(100, "f8_sync");
      exp_q.push_back('{lvl: 1'b1, len: 27});
      exp_q.push_back('{lvl: 1'b0, len: 27});
      push_phases(1'b1, 54, 4);
      step(10);
      oversampling_factor = 5'd8;
      wait_drain(500, "f8_drain");

      // factor 0 while high: low on next edge and stays quiet
      wait_rise(200, "z_sync");
      step(5);
      oversampling_factor = 5'd0;
      step(1);
      check("zero_low", longint'(oversampling_clock), 0);
      t0 = n_toggles;
      step(100);
      check("zero_quiet", longint'(n_toggles - t0), 0);
      check("zero_hold", longint'(oversampling_clock), 0);
      oversampling_factor = 5'd16;
      wait_rise(150, "z_resume");
      push_phases(1'b1, 27, 4);
      wait_drain(300, "z_drain");

      // rate_bd 0 behaves the same way
      wait_rise(100, "r0_sync");
      step(3);
      rate_bd = 32'd0;
      step(1);
      check("rate0_low", longint'(oversampling_clock), 0);
      t0 = n_toggles;
      step(20);
      check("rate0_quiet", longint'(n_toggles - t0), 0);
      rate_bd = 32'd115_200;
      wait_rise(150, "r0_resume");
      push_phases(1'b1, 27, 2);
      wait_drain(200, "r0_drain");

      // Reset in the middle of a division and a high phase
      wait_rise(100, "rst_sync");
      step(5);
      oversampling_factor = 5'd8;
      step(5);
      rst = 1'b0;
      #1;
      check("rst_async_out", longint'(oversampling_clock), 0);
`ifdef OVSCLK_TICK_EN
      check("rst_async_tick", longint'(ovs_tick), 0);
`endif
      step(3);
      rst = 1'b1;
      wait_rise(130, "rst_resume");
      push_phases(1'b1, 54, 4);
      wait_drain(600, "rst_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
